// File: rtl/weight_load_ctrl.sv
// Weight load sequencer: streams F*F weights into a PE row array in row-major order.
// Optional running checksum output is enabled by defining WLC_CHECKSUM_EN.
module weight_load_ctrl #(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned MAX_FILTER_WIDTH = 11,
  localparam int unsigned LOG_MFW         = $clog2(MAX_FILTER_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [LOG_MFW:0]      i_filter_width,
  input  logic [DATA_WIDTH-1:0] i_s_weight_data,
  input  logic                  i_s_weight_valid,
  output logic                  o_s_weight_ready,
  output logic [DATA_WIDTH-1:0] o_weight_data,
  output logic                  o_weight_valid,
  output logic [LOG_MFW:0]      o_wr_w_row_ptr,
  output logic [LOG_MFW:0]      o_wr_w_col_ptr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_cfg_err
`ifdef WLC_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] o_checksum
`endif
);

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  localparam logic [LOG_MFW:0] MaxF = (LOG_MFW + 1)'(MAX_FILTER_WIDTH);
  localparam logic [LOG_MFW:0] One  = (LOG_MFW + 1)'(1);

  state_e                state_q, state_d;
  logic [LOG_MFW:0]      f_q, f_d;
  logic [LOG_MFW:0]      row_q, row_d;
  logic [LOG_MFW:0]      col_q, col_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wvalid_q, wvalid_d;
  logic [LOG_MFW:0]      rptr_q, rptr_d;
  logic [LOG_MFW:0]      cptr_q, cptr_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [LOG_MFW:0] f_last;
  logic             start_ok;
  logic             start_acc;
  logic             beat;

  assign f_last    = f_q - One;
  assign start_ok  = (i_filter_width != '0) && (i_filter_width <= MaxF);
  assign start_acc = (state_q == StIdle) && i_start && start_ok && !i_abort;
  assign beat      = (state_q == StLoad) && i_s_weight_valid && !i_abort;

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    row_d     = row_q;
    col_d     = col_q;
    wdata_d   = wdata_q;
    rptr_d    = rptr_q;
    cptr_d    = cptr_q;
    wvalid_d  = 1'b0;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    if (i_abort) begin
      // Abort beats both a start and a same-cycle beat; pointers simply hold.
      state_d = StIdle;
      row_d   = '0;
      col_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            if (start_ok) begin
              state_d = StLoad;
              f_d     = i_filter_width;
              row_d   = '0;
              col_d   = '0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        StLoad: begin
          if (i_s_weight_valid) begin
            wvalid_d = 1'b1;
            wdata_d  = i_s_weight_data;
            rptr_d   = row_q;
            cptr_d   = col_q;
            if (col_q == f_last) begin
              col_d = '0;
              if (row_q == f_last) begin
                row_d   = '0;
                state_d = StIdle;
                done_d  = 1'b1;
              end else begin
                row_d = row_q + One;
              end
            end else begin
              col_d = col_q + One;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      f_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      rptr_q    <= '0;
      cptr_q    <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      f_q       <= f_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      rptr_q    <= rptr_d;
      cptr_q    <= cptr_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign o_s_weight_ready = (state_q == StLoad);
  assign o_busy           = (state_q == StLoad);
  assign o_weight_data    = wdata_q;
  assign o_weight_valid   = wvalid_q;
  assign o_wr_w_row_ptr   = rptr_q;
  assign o_wr_w_col_ptr   = cptr_q;
  assign o_done           = done_q;
  assign o_cfg_err        = cfg_err_q;

`ifdef WLC_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (i_abort || start_acc) begin
      sum_d = '0;
    end else if (beat) begin
      sum_d = sum_q + i_s_weight_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign o_checksum = sum_q;
`else
  // Checksum path absent in this build; start_acc and beat only feed it.
  logic unused_sum;
  assign unused_sum = start_acc ^ beat;
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: index-based reference model plus directed loads.
module tb_weight_load_ctrl;

  localparam int DW = 16;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, s_valid;
  logic [PW-1:0] fw;
  logic [DW-1:0] s_data;
  logic          s_ready, w_valid, busy, done, cfg_err;
  logic [DW-1:0] w_data;
  logic [PW-1:0] row_ptr, col_ptr;
`ifdef WLC_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  weight_load_ctrl #(.DATA_WIDTH(DW), .MAX_FILTER_WIDTH(11)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .i_start          (start),
    .i_abort          (abort),
    .i_filter_width   (fw),
    .i_s_weight_data  (s_data),
    .i_s_weight_valid (s_valid),
    .o_s_weight_ready (s_ready),
    .o_weight_data    (w_data),
    .o_weight_valid   (w_valid),
    .o_wr_w_row_ptr   (row_ptr),
    .o_wr_w_col_ptr   (col_ptr),
    .o_busy           (busy),
    .o_done           (done),
    .o_cfg_err        (cfg_err)
`ifdef WLC_CHECKSUM_EN
    ,
    .o_checksum       (checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: beat index n gives (n / F, n % F); load ends when n reaches F*F.
  bit      m_busy, m_valid, m_done, m_err;
  int      m_f, m_n;
  int      m_data, m_row, m_col, m_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_err = 0;
      m_f = 0; m_n = 0; m_data = 0; m_row = 0; m_col = 0; m_sum = 0;
    end else begin
      m_valid = 0; m_done = 0; m_err = 0;
      if (abort) begin
        m_busy = 0; m_n = 0; m_sum = 0;
      end else if (!m_busy) begin
        if (start) begin
          if (fw >= 1 && fw <= 11) begin
            m_busy = 1; m_f = int'(fw); m_n = 0; m_sum = 0;
          end else begin
            m_err = 1;
          end
        end
      end else if (s_valid) begin
        m_valid = 1;
        m_data  = int'(s_data);
        m_row   = m_n / m_f;
        m_col   = m_n % m_f;
        m_sum   = (m_sum + int'(s_data)) % 65536;
        m_n++;
        if (m_n == m_f * m_f) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  end

  // Per-test tallies observed from the DUT outputs.
  int n_strobe, n_done, n_err, n_busy, done_cyc;
  int last_data, last_row, last_col, sum_at_done;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    check("ready", 32'(s_ready), 32'(m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("wvalid", 32'(w_valid), 32'(m_valid));
    check("done", 32'(done), 32'(m_done));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    if (m_valid || !rst_n) begin
      check("wdata", 32'(w_data), 32'(m_data));
      check("row_ptr", 32'(row_ptr), 32'(m_row));
      check("col_ptr", 32'(col_ptr), 32'(m_col));
    end
`ifdef WLC_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(m_sum));
`endif
    if (w_valid) begin
      n_strobe++;
      last_data = int'(w_data); last_row = int'(row_ptr); last_col = int'(col_ptr);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
`ifdef WLC_CHECKSUM_EN
      sum_at_done = int'(checksum);
`endif
    end
    if (cfg_err) n_err++;
    if (busy) n_busy++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tallies();
    n_strobe = 0; n_done = 0; n_err = 0; n_busy = 0; done_cyc = -1;
    last_data = -1; last_row = -1; last_col = -1; sum_at_done = -1;
  endtask

  task automatic do_start(input logic [PW-1:0] f);
    start = 1'b1; fw = f;
    step();
    start = 1'b0;
  endtask

  int start_cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; fw = '0; s_data = '0;
    clear_tallies();
    repeat (3) step();
    check("reset_valid", 32'(w_valid), 32'd0);
    check("reset_ready", 32'(s_ready), 32'd0);
    check("reset_row", 32'(row_ptr), 32'd0);
    rst_n = 1'b1;
    step();

    // F=3, valid held high, words 1..9.
    clear_tallies();
    start_cyc = cyc;
    do_start(5'd3);
    for (int k = 1; k <= 9; k++) begin
      s_valid = 1'b1; s_data = 16'(k);
      step();
    end
    s_valid = 1'b0;
    repeat (3) step();
    check("t1_strobes", 32'(n_strobe), 32'd9);
    check("t1_done_cnt", 32'(n_done), 32'd1);
    check("t1_busy_cycles", 32'(n_busy), 32'd9);
    check("t1_start_to_done", 32'(done_cyc - start_cyc), 32'd10);
    check("t1_last_word", 32'(last_data), 32'd9);
    check("t1_last_row", 32'(last_row), 32'd2);
    check("t1_last_col", 32'(last_col), 32'd2);

    // F=2, valid toggling.
    clear_tallies();
    do_start(5'd2);
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_data = 16'(10 + k);
      step();
      s_valid = 1'b0; s_data = 16'hdead;
      step();
    end
    repeat (2) step();
    check("t2_strobes", 32'(n_strobe), 32'd4);
    check("t2_done_cnt", 32'(n_done), 32'd1);
    check("t2_last_word", 32'(last_data), 32'h000d);
    check("t2_last_row", 32'(last_row), 32'd1);

    // Illegal filter widths.
    clear_tallies();
    do_start(5'd0);
    step();
    do_start(5'd12);
    repeat (3) step();
    check("t3_cfg_err_cnt", 32'(n_err), 32'd2);
    check("t3_busy_cycles", 32'(n_busy), 32'd0);
    check("t3_strobes", 32'(n_strobe), 32'd0);

    // Abort after 4 beats with a beat in the abort cycle, then F=1 load.
    clear_tallies();
    do_start(5'd3);
    for (int k = 1; k <= 4; k++) begin
      s_valid = 1'b1; s_data = 16'(20 + k);
      step();
    end
    abort = 1'b1; s_data = 16'h0099;
    step();
    abort = 1'b0; s_valid = 1'b0;
    check("t4_idle_after_abort", 32'(busy), 32'd0);
    repeat (2) step();
    check("t4_strobes", 32'(n_strobe), 32'd4);
    check("t4_done_cnt", 32'(n_done), 32'd0);
    clear_tallies();
    do_start(5'd1);
    s_valid = 1'b1; s_data = 16'h0055;
    step();
    s_valid = 1'b0;
    repeat (2) step();
    check("t4b_strobes", 32'(n_strobe), 32'd1);
    check("t4b_done_cnt", 32'(n_done), 32'd1);
    check("t4b_word", 32'(last_data), 32'h0055);
    check("t4b_row", 32'(last_row), 32'd0);
    check("t4b_col", 32'(last_col), 32'd0);

    // Reset mid-load after 5 of 9 beats, then a fresh load.
    do_start(5'd3);
    for (int k = 1; k <= 5; k++) begin
      s_valid = 1'b1; s_data = 16'(30 + k);
      step();
    end
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(w_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_data", 32'(w_data), 32'd0);
    check("t5_rst_col", 32'(col_ptr), 32'd0);
    s_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    clear_tallies();
    do_start(5'd3);
    for (int k = 1; k <= 9; k++) begin
      s_valid = 1'b1; s_data = 16'(40 + k);
      step();
    end
    s_valid = 1'b0;
    repeat (2) step();
    check("t5_strobes", 32'(n_strobe), 32'd9);
    check("t5_done_cnt", 32'(n_done), 32'd1);
    check("t5_last_word", 32'(last_data), 32'd49);

`ifdef WLC_CHECKSUM_EN
    // Checksum wraps; a start during LOAD must not disturb the load.
    clear_tallies();
    do_start(5'd2);
    s_valid = 1'b1; s_data = 16'hffff; step();
    s_data = 16'h0002; start = 1'b1; fw = 5'd1; step();
    start = 1'b0;
    s_data = 16'h0003; step();
    s_data = 16'h0004; step();
    s_valid = 1'b0;
    repeat (2) step();
    check("t6_checksum", 32'(sum_at_done), 32'h0008);
    check("t6_strobes", 32'(n_strobe), 32'd4);
    check("t6_done_cnt", 32'(n_done), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_load_ctrl.md
# weight_load_ctrl

Sequencer that loads a square filter of weights into a PE row array. It accepts a valid/ready weight stream and drives the array's shared weight write bus: data, valid and the row/column write pointers in row-major order. It runs one load per start pulse and reports completion. It sits between the weight buffer/DMA and the per-row weight write ports.

## Interface
- DATA_WIDTH, 16, weight word width
- MAX_FILTER_WIDTH, 11, max filter side; also PEs per row and number of rows
- LOG_MFW (localparam), $clog2(MAX_FILTER_WIDTH), pointer/config index width base
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- i_start  input  1  pulse; begins a load when idle
- i_abort  input  1  synchronous; terminates load, returns to IDLE
- i_filter_width  input  LOG_MFW+1  filter side F, sampled on accepted i_start
- i_s_weight_data  input  DATA_WIDTH  incoming weight word
- i_s_weight_valid  input  1  incoming word valid
- o_s_weight_ready  output  1  controller accepts word this cycle
- o_weight_data  output  DATA_WIDTH  to array weight bus
- o_weight_valid  output  1  one-cycle write strobe per word
- o_wr_w_row_ptr  output  LOG_MFW+1  destination row of current word
- o_wr_w_col_ptr  output  LOG_MFW+1  destination column of current word
- o_busy  output  1  high in LOAD
- o_done  output  1  pulse with last word's write strobe
- o_cfg_err  output  1  pulse; start rejected for illegal F

## Operation
- States: IDLE, LOAD.
- IDLE: i_start with 1 <= i_filter_width <= MAX_FILTER_WIDTH latches F, clears row/col counters, and moves to LOAD. With F = 0 or F > MAX_FILTER_WIDTH, o_cfg_err pulses for one cycle and the state stays IDLE.
- i_start outside IDLE is ignored; the latched F cannot change mid-load.
- LOAD: o_s_weight_ready = 1, held unconditionally; there is no downstream backpressure. A beat is accepted on i_s_weight_valid & o_s_weight_ready.
- Per accepted beat:
  - The word and the current (row, col) pass to the output registers.
  - col increments. At col = F-1, col wraps to 0 and row increments.
  - On the beat where row = F-1 and col = F-1 (the F*F-th beat), the state goes to IDLE and o_done is set.
- Cycles without a beat (valid low) hold the counters and pointers, and drop o_weight_valid.
- i_abort (any state) has priority over i_start and over a same-cycle beat:
  - next state IDLE, counters cleared
  - o_weight_valid, o_done and o_cfg_err are 0 next cycle
  - no further words are written
- Counters use LOG_MFW+1 bits. Compare against F-1 only; no value beyond F-1 is ever produced.

## Timing
- Reset values: state IDLE; o_s_weight_ready 0; o_weight_valid 0; o_done 0; o_cfg_err 0; o_busy 0; o_weight_data 0; o_wr_w_row_ptr 0; o_wr_w_col_ptr 0; checksum 0.
- Start at cycle t gives LOAD and ready at t+1.
- A beat accepted at cycle k appears on the o_weight_* outputs at k+1 for exactly one cycle. Throughput is one word per cycle.
- Last beat accepted at k:
  - at k+1: o_weight_valid = 1, o_done = 1, o_busy = 0, o_s_weight_ready = 0
  - a new i_start is accepted at k+1 at earliest
- Minimum load time is F*F+1 cycles from start to done.
- o_cfg_err is asserted in the cycle after the rejected start.
- All outputs are registered; no combinational input-to-output path except none.

## Configuration
- WLC_CHECKSUM_EN defined:
  - adds output o_checksum [DATA_WIDTH-1:0]
  - the sum modulo 2^DATA_WIDTH of all accepted words in the current load
  - cleared on accepted start and on abort
  - final value valid from the o_done cycle until the next start
- Undefined: port and adder are absent; all other behaviour is identical.

## Test plan
- F=3, valid held high, words 1..9 → nine strobes, pointers (0,0),(0,1),(0,2),(1,0)…(2,2), o_done with word 9, busy for 9 cycles, total 10 cycles start to done.
- F=2, valid toggling 1/0, words 0xA,0xB,0xC,0xD → strobes only after valid cycles, pointers (0,0),(0,1),(1,0),(1,1), done on the 4th strobe.
- i_start with F=0, then F=12 (MAX=11) → o_cfg_err pulses twice, busy stays 0, no strobes.
- F=3, abort after 4 beats with a beat present in the abort cycle → only 4 strobes, no done, IDLE next cycle. A following F=1 load of word 0x55 → one strobe at (0,0) with done.
- Reset (low) asserted mid-load after 5 of 9 beats → all outputs 0 immediately, state IDLE. After release, a fresh F=3 load completes normally.
- WLC_CHECKSUM_EN, F=2, words 0xFFFF,0x0002,0x0003,0x0004 → o_checksum = 0x0008 at done. i_start during LOAD is ignored, with no counter or F change.
